trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_if.sv | 37 +++
 rtl/trap_controller.sv | 139 +++++++++++++
 tb/tb_trap_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// Trap-controller bus: exception/MRET/interrupt requests in, trap commit and fetch control out.
// Signal names match the trap controller's port list one to one.
interface trap_controller_if;
    logic        eip;
    logic        tip;
    logic        sip;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_req;
    logic        pipeline_busy;
    logic [31:0] resume_pc;

    logic        traped;
    logic        mret;
    logic        interupt;
    logic [3:0]  trap_cause;
    logic [31:0] ecp;
    logic        stall_fetch;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_sel;
    logic        busy;

    // The controller is the slave; csr/writeback/fetch together form the master side.
    modport slave (
        input  eip, tip, sip, exc_valid, exc_cause, exc_pc, mret_req, pipeline_busy, resume_pc,
        output traped, mret, interupt, trap_cause, ecp, stall_fetch, flush, redirect_valid,
               redirect_sel, busy
    );

    modport master (
        output eip, tip, sip, exc_valid, exc_cause, exc_pc, mret_req, pipeline_busy, resume_pc,
        input  traped, mret, interupt, trap_cause, ecp, stall_fetch, flush, redirect_valid,
               redirect_sel, busy
    );
endinterface

// File: rtl/trap_controller.sv
// Trap controller: sequences exceptions, MRET and drained interrupts into commit + redirect.
// Define TRAP_CONTROLLER_SOFT_IRQ_EN to let sip raise a software interrupt (cause 3).
module trap_controller (
    input  logic              clk,
    input  logic              rst_n,
    trap_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        RETURN,
        REDIRECT
    } state_e;

    localparam logic [3:0] CAUSE_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_SOFT  = 4'd3;
    localparam logic [3:0] CAUSE_TIMER = 4'd7;

    state_e      state_q, state_d;
    logic [3:0]  trap_cause_q, trap_cause_d;
    logic [31:0] ecp_q, ecp_d;
    logic        interupt_q, interupt_d;
    logic        redirect_sel_q, redirect_sel_d;

    logic        sip_en;
    logic        irq_pending;
    logic [3:0]  irq_cause;

`ifdef TRAP_CONTROLLER_SOFT_IRQ_EN
    assign sip_en = bus.sip;
`else
    assign sip_en = 1'b0;
`endif

    assign irq_pending = bus.eip | bus.tip | sip_en;

    // External beats software beats timer.
    always_comb begin
        if (bus.eip)     irq_cause = CAUSE_EXT;
        else if (sip_en) irq_cause = CAUSE_SOFT;
        else             irq_cause = CAUSE_TIMER;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            trap_cause_q   <= 4'd0;
            ecp_q          <= 32'd0;
            interupt_q     <= 1'b0;
            redirect_sel_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            trap_cause_q   <= trap_cause_d;
            ecp_q          <= ecp_d;
            interupt_q     <= interupt_d;
            redirect_sel_q <= redirect_sel_d;
        end
    end

    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        trap_cause_d   = trap_cause_q;
        ecp_d          = ecp_q;
        interupt_d     = interupt_q;
        redirect_sel_d = redirect_sel_q;

        unique case (state_q)
            IDLE: begin
                if (bus.exc_valid) begin
                    trap_cause_d = bus.exc_cause;
                    ecp_d        = bus.exc_pc;
                    interupt_d   = 1'b0;
                    state_d      = COMMIT;
                end else if (bus.mret_req) begin
                    state_d = RETURN;
                end else if (irq_pending) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A late exception from writeback wins over the interrupt being drained for.
                if (bus.exc_valid) begin
                    trap_cause_d = bus.exc_cause;
                    ecp_d        = bus.exc_pc;
                    interupt_d   = 1'b0;
                    state_d      = COMMIT;
                end else if (!bus.pipeline_busy) begin
                    if (irq_pending) begin
                        trap_cause_d = irq_cause;
                        ecp_d        = bus.resume_pc;
                        interupt_d   = 1'b1;
                        state_d      = COMMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                redirect_sel_d = 1'b0;
                state_d        = REDIRECT;
            end
            RETURN: begin
                redirect_sel_d = 1'b1;
                state_d        = REDIRECT;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.traped         = 1'b0;
        bus.mret           = 1'b0;
        bus.stall_fetch    = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.busy           = (state_q != IDLE);
        bus.trap_cause     = trap_cause_q;
        bus.ecp            = ecp_q;
        bus.interupt       = interupt_q;
        bus.redirect_sel   = redirect_sel_q;

        unique case (state_q)
            DRAIN:    bus.stall_fetch = 1'b1;
            COMMIT:   bus.traped      = 1'b1;
            RETURN:   bus.mret        = 1'b1;
            REDIRECT: begin
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exception, MRET, interrupt drain, priority races and reset.
module tb_trap_controller;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    trap_controller_if bus ();

    trap_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Outputs are registered, so sampling 1 ns after the edge sees the new state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        bus.eip           = 1'b0;
        bus.tip           = 1'b0;
        bus.sip           = 1'b0;
        bus.exc_valid     = 1'b0;
        bus.exc_cause     = 4'd0;
        bus.exc_pc        = 32'd0;
        bus.mret_req      = 1'b0;
        bus.pipeline_busy = 1'b0;
        bus.resume_pc     = 32'd0;

        tick();
        check("rst_busy",   bus.busy,           0);
        check("rst_traped", bus.traped,         0);
        check("rst_flush",  bus.flush,          0);
        check("rst_ecp",    bus.ecp,            0);
        check("rst_cause",  bus.trap_cause,     0);
        rst_n = 1'b1;
        tick();

        // Exception from IDLE.
        bus.exc_valid = 1'b1; bus.exc_cause = 4'd2; bus.exc_pc = 32'h100;
        tick();
        bus.exc_valid = 1'b0;
        check("exc_traped",   bus.traped,     1);
        check("exc_cause",    bus.trap_cause, 2);
        check("exc_ecp",      bus.ecp,        32'h100);
        check("exc_interupt", bus.interupt,   0);
        check("exc_flush0",   bus.flush,      0);
        tick();
        check("exc_traped_once", bus.traped,         0);
        check("exc_flush",       bus.flush,          1);
        check("exc_rvalid",      bus.redirect_valid, 1);
        check("exc_rsel",        bus.redirect_sel,   0);
        tick();
        check("exc_idle",       bus.busy,       0);
        check("exc_flush_once", bus.flush,      0);
        check("exc_hold_cause", bus.trap_cause, 2);

        // MRET, with a stray exception during RETURN that must be ignored.
        bus.mret_req = 1'b1;
        tick();
        bus.mret_req = 1'b0;
        check("mret_pulse",  bus.mret,   1);
        check("mret_traped", bus.traped, 0);
        bus.exc_valid = 1'b1; bus.exc_cause = 4'd6; bus.exc_pc = 32'h600;
        tick();
        bus.exc_valid = 1'b0;
        check("mret_once",    bus.mret,         0);
        check("mret_traped2", bus.traped,       0);
        check("mret_flush",   bus.flush,        1);
        check("mret_rsel",    bus.redirect_sel, 1);
        check("mret_ignore",  bus.ecp,          32'h100);
        tick();
        check("mret_idle", bus.busy, 0);

        // Timer interrupt waiting out a busy pipeline.
        bus.tip = 1'b1; bus.pipeline_busy = 1'b1; bus.resume_pc = 32'h2004;
        tick();
        check("drain_stall1", bus.stall_fetch, 1);
        check("drain_busy",   bus.busy,        1);
        tick();
        check("drain_stall2", bus.stall_fetch, 1);
        tick();
        check("drain_stall3", bus.stall_fetch, 1);
        check("drain_notrap", bus.traped,      0);
        bus.pipeline_busy = 1'b0;
        tick();
        bus.tip = 1'b0;
        check("irq_traped",   bus.traped,      1);
        check("irq_cause",    bus.trap_cause,  7);
        check("irq_interupt", bus.interupt,    1);
        check("irq_ecp",      bus.ecp,         32'h2004);
        check("irq_nostall",  bus.stall_fetch, 0);
        tick();
        check("irq_flush", bus.flush,        1);
        check("irq_rsel",  bus.redirect_sel, 0);
        tick();
        check("irq_idle", bus.busy, 0);

        // Exception and MRET together: exception wins.
        bus.exc_valid = 1'b1; bus.mret_req = 1'b1; bus.exc_cause = 4'd4; bus.exc_pc = 32'h400;
        tick();
        bus.exc_valid = 1'b0; bus.mret_req = 1'b0;
        check("race_traped", bus.traped,     1);
        check("race_nomret", bus.mret,       0);
        check("race_cause",  bus.trap_cause, 4);
        tick();
        check("race_nomret2", bus.mret,         0);
        check("race_rsel",    bus.redirect_sel, 0);
        tick();

        // All interrupt sources pending: external wins.
        bus.eip = 1'b1; bus.sip = 1'b1; bus.tip = 1'b1; bus.resume_pc = 32'h3000;
        tick();
        check("prio_drain", bus.stall_fetch, 1);
        tick();
        bus.eip = 1'b0; bus.sip = 1'b0; bus.tip = 1'b0;
        check("prio_traped", bus.traped,     1);
        check("prio_cause",  bus.trap_cause, 11);
        check("prio_ecp",    bus.ecp,        32'h3000);
        tick();
        tick();
        check("prio_idle", bus.busy, 0);

        // Exception arriving during DRAIN abandons the interrupt.
        bus.eip = 1'b1; bus.pipeline_busy = 1'b1;
        tick();
        check("dexc_drain", bus.stall_fetch, 1);
        bus.exc_valid = 1'b1; bus.exc_cause = 4'd5; bus.exc_pc = 32'h300;
        tick();
        bus.exc_valid = 1'b0; bus.eip = 1'b0; bus.pipeline_busy = 1'b0;
        check("dexc_traped",   bus.traped,     1);
        check("dexc_interupt", bus.interupt,   0);
        check("dexc_cause",    bus.trap_cause, 5);
        check("dexc_ecp",      bus.ecp,        32'h300);
        tick();
        tick();
        check("dexc_idle", bus.busy, 0);

        // Interrupt withdrawn while draining: back to IDLE with no trap.
        bus.eip = 1'b1; bus.pipeline_busy = 1'b1;
        tick();
        check("wd_drain", bus.stall_fetch, 1);
        bus.eip = 1'b0;
        tick();
        check("wd_still_drain", bus.stall_fetch, 1);
        bus.pipeline_busy = 1'b0;
        tick();
        check("wd_idle",   bus.busy,   0);
        check("wd_notrap", bus.traped, 0);
        check("wd_noflsh", bus.flush,  0);
        tick();
        check("wd_noflsh2", bus.flush, 0);

        // Reset asserted during COMMIT takes effect without a clock edge.
        bus.exc_valid = 1'b1; bus.exc_cause = 4'd9; bus.exc_pc = 32'h44;
        tick();
        bus.exc_valid = 1'b0;
        check("mid_commit", bus.traped, 1);
        rst_n = 1'b0;
        #1;
        check("mid_traped", bus.traped,     0);
        check("mid_busy",   bus.busy,       0);
        check("mid_ecp",    bus.ecp,        0);
        check("mid_cause",  bus.trap_cause, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_flush",  bus.flush,  0);
        check("post_traped", bus.traped, 0);
        tick();
        check("post_flush2", bus.flush, 0);

        // Software interrupt alone.
        bus.sip = 1'b1; bus.resume_pc = 32'h5000;
        tick();
`ifdef TRAP_CONTROLLER_SOFT_IRQ_EN
        check("sip_drain", bus.stall_fetch, 1);
        tick();
        bus.sip = 1'b0;
        check("sip_traped", bus.traped,     1);
        check("sip_cause",  bus.trap_cause, 3);
        tick();
        tick();
`else
        check("sip_ignored", bus.busy, 0);
        tick();
        check("sip_ignored2", bus.traped, 0);
        bus.sip = 1'b0;
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
